pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 148 ++++++++++++++
 tb/tb_pwm_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in clk cycles.
// Optional glitch filter after the synchroniser is enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic [WIDTH-1:0] period_out,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   prev_q;
  logic                   rise;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;

  // Shift pwm_in through the synchroniser; the last stage is the metastability-safe copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic filt_q;

  // Follow the input only once two adjacent synchroniser stages agree, so 1-cycle pulses never pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
      filt_q <= sync_q[SYNC_STAGES-2];
    end
  end

  assign pwm_s = filt_q;
`else
  assign pwm_s = sync_q[SYNC_STAGES-1];
`endif

  assign rise = pwm_s & ~prev_q;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;
    stuck_d      = stuck_q;

    if (!enable) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            state_d      = MEASURE;
          end
        end
        default: begin
          // A rise takes priority over the timeout check so a full-length period still reports.
          if (rise) begin
            period_d     = period_cnt_q;
            duty_d       = high_cnt_q;
            valid_d      = 1'b1;
            timeout_d    = 1'b0;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else if (period_cnt_q == CNT_MAX) begin
            timeout_d    = 1'b1;
            stuck_d      = pwm_s;
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            if (pwm_s && (high_cnt_q != CNT_MAX)) begin
              high_cnt_d = high_cnt_q + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= 1'b0;
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      prev_q       <= pwm_s;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      stuck_q      <= stuck_d;
    end
  end

  assign duty_out    = duty_q;
  assign period_out  = period_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus random PWM trains,
// compared every cycle against a timeline model built from the driven input history.
module tb_pwm_capture;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int MAXC  = 8192;
  localparam int TMO   = (1 << WIDTH) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             enable;
  logic             pwm_in;
  logic [WIDTH-1:0] duty_out;
  logic [WIDTH-1:0] period_out;
  logic             valid;
  logic             timeout;
  logic             stuck_level;

  int total;
  int bad;
  int cyc;

  // The model reasons on the input timeline: the level the DUT sees is the driven (optionally
  // filtered) level, shifted by the synchroniser depth, and results are rise-to-rise statistics.
  logic rawLvl  [0:MAXC-1];
  logic filtLvl [0:MAXC-1];
  bit   havePrev;
  int   prevRise;
  int   expDuty;
  int   expPeriod;
  bit   expValid;
  bit   expTimeout;
  bit   expStuck;

  pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .timeout    (timeout),
    .stuck_level(stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one clock edge using what the DUT could have seen at that edge.
  task automatic modelEdge(input logic en, input logic rst);
    int  k;
    int  acc;
    bit  rise;
    if (FILT && cyc >= 1)
      filtLvl[cyc] = (rawLvl[cyc] == rawLvl[cyc-1]) ? rawLvl[cyc] : filtLvl[cyc-1];
    else
      filtLvl[cyc] = rawLvl[cyc];
    expValid = 1'b0;
    if (rst) begin
      havePrev   = 1'b0;
      expDuty    = 0;
      expPeriod  = 0;
      expTimeout = 1'b0;
      expStuck   = 1'b0;
    end else begin
      k    = cyc - SYNC;
      rise = (k >= 1) && (filtLvl[k] === 1'b1) && (filtLvl[k-1] === 1'b0);
      if (!en) begin
        havePrev   = 1'b0;
        expTimeout = 1'b0;
      end else if (!havePrev) begin
        if (rise) begin
          havePrev = 1'b1;
          prevRise = k;
        end
      end else if (rise) begin
        acc = 0;
        for (int j = prevRise; j < k; j++) acc += int'(filtLvl[j]);
        expValid   = 1'b1;
        expPeriod  = k - prevRise;
        expDuty    = acc;
        expTimeout = 1'b0;
        prevRise   = k;
      end else if (k - prevRise == TMO) begin
        expTimeout = 1'b1;
        expStuck   = filtLvl[k];
        havePrev   = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    check("valid", 32'(valid), 32'(expValid));
    check("duty_out", 32'(duty_out), 32'(expDuty));
    check("period_out", 32'(period_out), 32'(expPeriod));
    check("timeout", 32'(timeout), 32'(expTimeout));
    check("stuck_level", 32'(stuck_level), 32'(expStuck));
  endtask

  // One clock cycle: drive at the falling edge, let the rising edge happen, check at the next fall.
  task automatic applyStimulus(input logic pin, input logic en);
    pwm_in = pin;
    enable = en;
    rawLvl[cyc+1] = pin;
    @(posedge clk);
    cyc++;
    modelEdge(en, reset);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic resetCycle();
    pwm_in = 1'b0;
    rawLvl[cyc+1] = 1'b0;
    @(posedge clk);
    cyc++;
    modelEdge(1'b0, 1'b1);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleLow(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, en);
  endtask

  task automatic runPwm(input int period, input int high, input int nPeriods);
    for (int i = 0; i < period * nPeriods; i++) applyStimulus(logic'((i % period) < high), 1'b1);
  endtask

  initial begin
    int p;
    int h;
    int n;
    total = 0;
    bad   = 0;
    cyc   = 0;
    havePrev   = 1'b0;
    prevRise   = 0;
    expDuty    = 0;
    expPeriod  = 0;
    expValid   = 1'b0;
    expTimeout = 1'b0;
    expStuck   = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      rawLvl[i]  = 1'b0;
      filtLvl[i] = 1'b0;
    end
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;

    $display("[TB] power-on reset");
    for (int i = 0; i < 3; i++) resetCycle();
    check("rst_duty", 32'(duty_out), 32'd0);
    check("rst_period", 32'(period_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_stuck", 32'(stuck_level), 32'd0);
    reset = 1'b0;

    $display("[TB] period 10 high 3, four periods");
    idleLow(4, 1'b1);
    runPwm(10, 3, 4);
    check("p10_duty", 32'(duty_out), 32'd3);
    check("p10_period", 32'(period_out), 32'd10);
    check("p10_timeout", 32'(timeout), 32'd0);

    $display("[TB] input stuck high");
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1);
    check("hi_timeout", 32'(timeout), 32'd1);
    check("hi_stuck", 32'(stuck_level), 32'd1);
    check("hi_duty_hold", 32'(duty_out), 32'd3);
    check("hi_period_hold", 32'(period_out), 32'd10);

    $display("[TB] restart with period 20 high 5");
    idleLow(5, 1'b1);
    runPwm(20, 5, 3);
    check("p20_duty", 32'(duty_out), 32'd5);
    check("p20_period", 32'(period_out), 32'd20);
    check("p20_timeout", 32'(timeout), 32'd0);

    $display("[TB] input stuck low");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    idleLow(300, 1'b1);
    check("lo_timeout", 32'(timeout), 32'd1);
    check("lo_stuck", 32'(stuck_level), 32'd0);
    check("lo_duty_hold", 32'(duty_out), 32'd5);
    check("lo_period_hold", 32'(period_out), 32'd20);

    $display("[TB] enable abort mid-period");
    idleLow(3, 1'b1);
    runPwm(10, 3, 2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    idleLow(2, 1'b1);
    idleLow(3, 1'b0);
    idleLow(2, 1'b1);
    runPwm(10, 3, 3);
    check("en_duty", 32'(duty_out), 32'd3);
    check("en_period", 32'(period_out), 32'd10);

    $display("[TB] asynchronous reset mid-period");
    runPwm(10, 3, 2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    idleLow(3, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_duty", 32'(duty_out), 32'd0);
    check("arst_period", 32'(period_out), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_timeout", 32'(timeout), 32'd0);
    check("arst_stuck", 32'(stuck_level), 32'd0);
    resetCycle();
    resetCycle();
    reset = 1'b0;
    idleLow(2, 1'b1);
    runPwm(10, 3, 3);

    $display("[TB] low glitch inside the high phase");
    idleLow(3, 1'b1);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      idleLow(6, 1'b1);
    end

    $display("[TB] random PWM trains");
    for (int s = 0; s < 8; s++) begin
      p = int'($urandom_range(40, 2));
      h = int'($urandom_range(p - 1, 1));
      n = int'($urandom_range(5, 3));
      idleLow(int'($urandom_range(5, 2)), 1'b1);
      runPwm(p, h, n);
    end
    idleLow(5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
